// File: rtl/digital_resonator_mc_if.sv
`default_nettype none
// ---- digital_resonator_mc_if : sample/coefficient/result bundle for the resonator | rev 1.0 ----
interface digital_resonator_mc_if #(
  parameter int DW  = 16,
  parameter int CW  = 16,
  parameter int CHW = 2
);
  logic                  in_valid;
  logic                  in_ready;
  logic signed [DW-1:0]  in_data;
  logic [CHW-1:0]        in_ch;
  logic signed [CW-1:0]  b0;
  logic signed [CW-1:0]  a1;
  logic signed [CW-1:0]  a2;
  logic                  clr_all;
  logic                  out_valid;
  logic signed [DW-1:0]  out_data;
  logic [CHW-1:0]        out_ch;
  logic                  ch_err;

  modport master (
    output in_valid, in_data, in_ch, b0, a1, a2, clr_all,
    input  in_ready, out_valid, out_data, out_ch, ch_err
  );

  modport slave (
    input  in_valid, in_data, in_ch, b0, a1, a2, clr_all,
    output in_ready, out_valid, out_data, out_ch, ch_err
  );
endinterface
`default_nettype wire

// File: rtl/digital_resonator_mc.sv
`default_nettype none
// ---- digital_resonator_mc : y = b0*x + a1*y1 + a2*y2 per channel, one shared multiplier | rev 1.0 ----
module digital_resonator_mc #(
  parameter int DW  = 16,
  parameter int CW  = 16,
  parameter int NCH = 4,
  parameter int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic clk,
  input  logic rst,
  digital_resonator_mc_if.slave io_bus
);

  localparam int ACCW = DW + CW + 2;
  localparam logic signed [ACCW-1:0] c_rnd  = {{(ACCW-CW+2){1'b0}}, 1'b1, {(CW-3){1'b0}}};
  localparam logic signed [ACCW-1:0] c_ymax = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACCW-1:0] c_ymin = {{(ACCW-DW+1){1'b1}}, {(DW-1){1'b0}}};
  localparam logic [CHW:0]           c_nch  = (CHW+1)'(NCH);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MB0  = 3'd1,
    S_MA1  = 3'd2,
    S_MA2  = 3'd3,
    S_WR   = 3'd4
  } state_t;

  state_t                 r_state;
  state_t                 w_next;

  logic signed [DW-1:0]   r_x;
  logic [CHW-1:0]         r_ch;
  logic signed [CW-1:0]   r_b0;
  logic signed [CW-1:0]   r_a1;
  logic signed [CW-1:0]   r_a2;
  logic signed [ACCW-1:0] r_acc;
  logic signed [DW-1:0]   r_y1 [NCH];
  logic signed [DW-1:0]   r_y2 [NCH];
  logic                   r_out_valid;
  logic signed [DW-1:0]   r_out_data;
  logic [CHW-1:0]         r_out_ch;
  logic                   r_ch_err;

  logic                   w_ch_ok;
  logic signed [DW-1:0]   w_y1_sel;
  logic signed [DW-1:0]   w_y2_sel;
  logic signed [CW-1:0]   w_coef;
  logic signed [DW-1:0]   w_samp;
  logic signed [DW+CW-1:0] w_prod;
  logic signed [ACCW-1:0] w_prod_ext;
  logic signed [ACCW-1:0] w_rsum;
  logic signed [ACCW-1:0] w_rsh;
  logic signed [DW-1:0]   w_y;

  assign w_ch_ok = ({1'b0, r_ch} < c_nch);

  // Explicit compare loop keeps an out-of-range channel from indexing past the state arrays.
  always_comb begin
    w_y1_sel = '0;
    w_y2_sel = '0;
    for (int i = 0; i < NCH; i++) begin
      if (r_ch == CHW'(i)) begin
        w_y1_sel = r_y1[i];
        w_y2_sel = r_y2[i];
      end
    end
  end

  always_comb begin
    w_coef = r_b0;
    w_samp = r_x;
    case (r_state)
      S_MA1: begin
        w_coef = r_a1;
        w_samp = w_y1_sel;
      end
      S_MA2: begin
        w_coef = r_a2;
        w_samp = w_y2_sel;
      end
      default: ;
    endcase
  end

  assign w_prod     = w_coef * w_samp;
  assign w_prod_ext = {{2{w_prod[DW+CW-1]}}, w_prod};

  assign w_rsum = r_acc + c_rnd;
  assign w_rsh  = w_rsum >>> (CW-2);

  always_comb begin
    if (w_rsh > c_ymax) begin
      w_y = c_ymax[DW-1:0];
    end else if (w_rsh < c_ymin) begin
      w_y = c_ymin[DW-1:0];
    end else begin
      w_y = w_rsh[DW-1:0];
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (io_bus.in_valid) w_next = S_MB0;
      S_MB0:   w_next = S_MA1;
      S_MA1:   w_next = S_MA2;
      S_MA2:   w_next = S_WR;
      S_WR:    w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (io_bus.clr_all) w_next = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x         <= '0;
      r_ch        <= '0;
      r_b0        <= '0;
      r_a1        <= '0;
      r_a2        <= '0;
      r_acc       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
      r_ch_err    <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        r_y1[i] <= '0;
        r_y2[i] <= '0;
      end
    end else begin
      r_out_valid <= 1'b0;
      if (io_bus.clr_all) begin
        r_ch_err <= 1'b0;
        for (int i = 0; i < NCH; i++) begin
          r_y1[i] <= '0;
          r_y2[i] <= '0;
        end
      end else begin
        case (r_state)
          S_IDLE: begin
            if (io_bus.in_valid) begin
              r_x  <= io_bus.in_data;
              r_ch <= io_bus.in_ch;
              r_b0 <= io_bus.b0;
              r_a1 <= io_bus.a1;
              r_a2 <= io_bus.a2;
            end
          end
          S_MB0: begin
            r_acc <= w_prod_ext;
            if (!w_ch_ok) r_ch_err <= 1'b1;
          end
          S_MA1, S_MA2: begin
            r_acc <= r_acc + w_prod_ext;
          end
          S_WR: begin
            // Dropped samples walk the pipeline but never publish or touch state.
            if (w_ch_ok) begin
              r_out_valid <= 1'b1;
              r_out_data  <= w_y;
              r_out_ch    <= r_ch;
              for (int i = 0; i < NCH; i++) begin
                if (r_ch == CHW'(i)) begin
                  r_y2[i] <= r_y1[i];
                  r_y1[i] <= w_y;
                end
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign io_bus.in_ready  = (r_state == S_IDLE);
  assign io_bus.out_valid = r_out_valid;
  assign io_bus.out_data  = r_out_data;
  assign io_bus.out_ch    = r_out_ch;
  assign io_bus.ch_err    = r_ch_err;

endmodule
`default_nettype wire
